// File: rtl/inst_buffer_pkg.sv
// Shared types and opcode constants for the fetch-to-decode instruction buffer.
// No logic of its own; imported by the predecoder, interface and buffer top.
// Entry widths are fixed at 32-bit instruction and 32-bit PC.
package inst_buffer_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;

   // Major opcode field inst[31:26] of the unconditional jumps
   localparam logic [5:0] OPC_B    = 6'b010100;
   localparam logic [5:0] OPC_BL   = 6'b010101;
   localparam logic [5:0] OPC_JIRL = 6'b010011;

   // Sub-opcode inst[28:24] that marks a store inside the memory group
   localparam logic [4:0] OPC_STORE_SUB = 5'b01001;

   // inst[31:24] of the CSR access group
   localparam logic [7:0] OPC_CSR = 8'b00000100;

   typedef enum logic [2:0] {
      PD_ALU    = 3'd0,
      PD_BRANCH = 3'd1,
      PD_JUMP   = 3'd2,
      PD_LOAD   = 3'd3,
      PD_STORE  = 3'd4,
      PD_CSR    = 3'd5
   } pd_class_t;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
      logic              pred_taken;
      logic [ADDR_W-1:0] pred_addr;
      pd_class_t         pd_class;
   } entry_t;

   function automatic logic is_jump(input logic [5:0] op);
      return (op == OPC_B) || (op == OPC_BL) || (op == OPC_JIRL);
   endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch/decode side bundle of the instruction buffer.
// master = fetch + decode + recovery (drives pushes, out_ready, flush).
// slave  = the buffer (drives in_ready, head fields, occupancy).
interface inst_buffer_if import inst_buffer_pkg::*; #(
   parameter int DEPTH       = 8,
   parameter int FETCH_WIDTH = 2,
   parameter int INST_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32
);
   logic                                 flush;
   logic [$clog2(FETCH_WIDTH+1)-1:0]     in_count;
   logic [FETCH_WIDTH*INST_WIDTH-1:0]    in_inst;
   logic [ADDR_WIDTH-1:0]                in_pc;
   logic [FETCH_WIDTH-1:0]               in_pred_taken;
   logic [ADDR_WIDTH-1:0]                in_pred_addr;
   logic                                 in_ready;
   logic                                 out_valid;
   logic                                 out_ready;
   logic [INST_WIDTH-1:0]                out_inst;
   logic [ADDR_WIDTH-1:0]                out_pc;
   logic                                 out_pred_taken;
   logic [ADDR_WIDTH-1:0]                out_pred_addr;
   pd_class_t                            out_class;
   logic [$clog2(DEPTH+1)-1:0]           occupancy;

   modport master (
      output flush, in_count, in_inst, in_pc, in_pred_taken, in_pred_addr, out_ready,
      input  in_ready, out_valid, out_inst, out_pc, out_pred_taken, out_pred_addr,
             out_class, occupancy
   );

   modport slave (
      input  flush, in_count, in_inst, in_pc, in_pred_taken, in_pred_addr, out_ready,
      output in_ready, out_valid, out_inst, out_pc, out_pred_taken, out_pred_addr,
             out_class, occupancy
   );
endinterface

// File: rtl/inst_predecode.sv
// Coarse instruction classifier used at buffer write time.
// Latency: purely combinational.
// Backpressure: none; one instance per fetch lane.
module inst_predecode import inst_buffer_pkg::*; (
   input  logic [INST_W-1:0] inst,
   output pd_class_t         pd_class
);

   // Priority decode: branch/jump group, then memory group, then CSR, else ALU
   always_comb begin
      pd_class = PD_ALU;
      if (inst[31:30] == 2'b01)
         pd_class = is_jump(inst[31:26]) ? PD_JUMP : PD_BRANCH;
      else if (inst[31:29] == 3'b001)
         pd_class = (inst[28:24] == OPC_STORE_SUB) ? PD_STORE : PD_LOAD;
      else if (inst[31:24] == OPC_CSR)
         pd_class = PD_CSR;
   end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction buffer: up to FETCH_WIDTH pushes/cycle, one pop/cycle to decode.
// Latency: push to out_valid 1 cycle; 0 cycles from empty with INST_BUFFER_BYPASS_EN.
// Backpressure: in_ready from occupancy only; head held stable while out_ready is low.
module inst_buffer import inst_buffer_pkg::*; #(
   parameter int DEPTH       = 8,
   parameter int FETCH_WIDTH = 2,
   parameter int INST_WIDTH  = INST_W,
   parameter int ADDR_WIDTH  = ADDR_W
) (
   input  logic         clk,
   input  logic         rst,
   inst_buffer_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(FETCH_WIDTH + 1);
   localparam int OW = $clog2(DEPTH + 1);

   entry_t          mem [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [OW-1:0]   occupancy;

   entry_t          lane_ent [FETCH_WIDTH];
   pd_class_t       lane_cls [FETCH_WIDTH];
   logic [CW-1:0]   eff_count;
   logic [CW-1:0]   skip;
   logic [CW-1:0]   push_n;
   logic            in_ready;
   logic            stored_valid;
   logic            accept;
   logic            bypass_vld;
   logic            bypass_take;
   logic            pop;
   entry_t          head_ent;

   // Per-lane entry assembly: predecode, sequential PC, target only on a taken lane
   for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
      inst_predecode u_pd (
         .inst     (bus.in_inst[i*INST_WIDTH +: INST_WIDTH]),
         .pd_class (lane_cls[i])
      );
      assign lane_ent[i] = '{
         inst:       bus.in_inst[i*INST_WIDTH +: INST_WIDTH],
         pc:         bus.in_pc + ADDR_WIDTH'(4 * i),
         pred_taken: bus.in_pred_taken[i],
         pred_addr:  bus.in_pred_taken[i] ? bus.in_pred_addr : '0,
         pd_class:   lane_cls[i]
      };
   end

   // Truncate the push just after the lowest-numbered predicted-taken lane
   always_comb begin
      eff_count = bus.in_count;
      for (int i = FETCH_WIDTH - 1; i >= 0; i--)
         if (bus.in_pred_taken[i] && (CW'(i) < bus.in_count))
            eff_count = CW'(i + 1);
   end

   assign in_ready     = occupancy <= OW'(DEPTH - FETCH_WIDTH);
   assign stored_valid = occupancy != '0;
   assign accept       = !bus.flush && in_ready && (eff_count != '0);

`ifdef INST_BUFFER_BYPASS_EN
   assign bypass_vld = !stored_valid && !bus.flush && (bus.in_count != '0);
`else
   assign bypass_vld = 1'b0;
`endif
   assign bypass_take = bypass_vld && bus.out_ready;

   // A bypassed lane 0 goes straight to decode and is not written
   assign skip   = CW'(bypass_take);
   assign push_n = accept ? (eff_count - skip) : '0;
   assign pop    = !bus.flush && !bypass_vld && stored_valid && bus.out_ready;

   // Head selection; zero data whenever nothing is valid
   always_comb begin
      head_ent = '0;
      if (bypass_vld)
         head_ent = lane_ent[0];
      else if (stored_valid)
         head_ent = mem[head];
   end

   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = stored_valid || bypass_vld;
   assign bus.out_inst       = head_ent.inst;
   assign bus.out_pc         = head_ent.pc;
   assign bus.out_pred_taken = head_ent.pred_taken;
   assign bus.out_pred_addr  = head_ent.pred_addr;
   assign bus.out_class      = head_ent.pd_class;
   assign bus.occupancy      = occupancy;

   // Entry storage write: accepted lanes land at consecutive slots from tail
   always_ff @(posedge clk) begin
      if (accept)
         for (int i = 0; i < FETCH_WIDTH; i++)
            if ((CW'(i) >= skip) && (CW'(i) < eff_count))
               mem[tail + PW'(i) - PW'(skip)] <= lane_ent[i];
   end

   // Pointer and occupancy update; flush dominates any push or pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else if (bus.flush) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else begin
         tail      <= tail + PW'(push_n);
         if (pop)
            head <= head + PW'(1);
         occupancy <= occupancy + OW'(push_n) - OW'(pop);
      end
   end

   // Fetch must never offer lanes while the buffer is not ready
   assert property (@(posedge clk) disable iff (rst || bus.flush)
                    !((bus.in_count != '0) && !in_ready));

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer (DEPTH=8, FETCH_WIDTH=2).
// Expected values are hand-derived; a PC counter tracks in-order delivery.
// Bypass-dependent latency checks follow INST_BUFFER_BYPASS_EN.
module tb_inst_buffer;
   import inst_buffer_pkg::*;

   localparam logic [31:0] ALU = 32'h0280_0000;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;
   logic [31:0] push_pc;
   logic [31:0] exp_pc;
   logic [31:0] cls_inst [6];
   pd_class_t   cls_exp  [6];

   inst_buffer_if #(.DEPTH(8), .FETCH_WIDTH(2), .INST_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   inst_buffer #(.DEPTH(8), .FETCH_WIDTH(2), .INST_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush         = 1'b0;
      bus.in_count      = '0;
      bus.in_pred_taken = '0;
      bus.out_ready     = 1'b0;
   endtask

   task automatic drive(input int n, input logic [31:0] pc, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [1:0] pt, input logic rdy);
      bus.in_count      = 2'(n);
      bus.in_pc         = pc;
      bus.in_inst       = {i1, i0};
      bus.in_pred_taken = pt;
      bus.out_ready     = rdy;
   endtask

   task automatic cyc(input int n, input logic [31:0] pc, input logic [31:0] i0,
                      input logic [31:0] i1, input logic [1:0] pt, input logic rdy);
      drive(n, pc, i0, i1, pt, rdy);
      tick();
      idle();
      #1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      bus.in_inst      = '0;
      bus.in_pc        = '0;
      bus.in_pred_addr = '0;
      idle();
      rst = 1'b1;
      #12;
      // reset state
      chk("rst_occ",   bus.occupancy, 0);
      chk("rst_vld",   bus.out_valid, 0);
      chk("rst_rdy",   bus.in_ready,  1);
      chk("rst_pc",    bus.out_pc,    0);
      chk("rst_inst",  bus.out_inst,  0);
      rst = 1'b0;
      tick();

      // first push: ALU then B
      drive(2, 32'h1C00_0000, 32'h0280_0421, 32'h5000_0400, 2'b00, 1'b0);
      #1;
`ifndef INST_BUFFER_BYPASS_EN
      chk("lat1_same_cycle_vld", bus.out_valid, 0);
`else
      chk("byp_same_cycle_vld", bus.out_valid, 1);
`endif
      tick(); idle(); #1;
      chk("p1_vld",   bus.out_valid, 1);
      chk("p1_occ",   bus.occupancy, 2);
      chk("p1_pc",    bus.out_pc,    32'h1C00_0000);
      chk("p1_inst",  bus.out_inst,  32'h0280_0421);
      chk("p1_class", bus.out_class, PD_ALU);
      cyc(0, 0, 0, 0, 2'b00, 1'b1);
      chk("p2_class", bus.out_class, PD_JUMP);
      chk("p2_pc",    bus.out_pc,    32'h1C00_0004);
      chk("p2_occ",   bus.occupancy, 1);
      cyc(0, 0, 0, 0, 2'b00, 1'b1);
      chk("p_empty_occ", bus.occupancy, 0);
      chk("p_empty_vld", bus.out_valid, 0);

      // predicted taken on lane 0 truncates lane 1
      bus.in_pred_addr = 32'h1C00_0100;
      cyc(2, 32'h1C00_0010, ALU, ALU, 2'b01, 1'b0);
      chk("pt0_occ",   bus.occupancy,      1);
      chk("pt0_taken", bus.out_pred_taken, 1);
      chk("pt0_addr",  bus.out_pred_addr,  32'h1C00_0100);
      chk("pt0_pc",    bus.out_pc,         32'h1C00_0010);
      cyc(0, 0, 0, 0, 2'b00, 1'b1);
      // predicted taken on lane 1 keeps both, target only on lane 1
      bus.in_pred_addr = 32'h1C00_0200;
      cyc(2, 32'h1C00_0020, ALU, ALU, 2'b10, 1'b0);
      chk("pt1_occ",    bus.occupancy,      2);
      chk("pt1_l0_tk",  bus.out_pred_taken, 0);
      chk("pt1_l0_adr", bus.out_pred_addr,  0);
      cyc(0, 0, 0, 0, 2'b00, 1'b1);
      chk("pt1_l1_tk",  bus.out_pred_taken, 1);
      chk("pt1_l1_adr", bus.out_pred_addr,  32'h1C00_0200);
      chk("pt1_l1_pc",  bus.out_pc,         32'h1C00_0024);
      cyc(0, 0, 0, 0, 2'b00, 1'b1);
      bus.in_pred_addr = '0;

      // predecode classes
      cls_inst[0] = 32'h2880_0000; cls_exp[0] = PD_LOAD;
      cls_inst[1] = 32'h2980_0000; cls_exp[1] = PD_STORE;
      cls_inst[2] = 32'h0400_0000; cls_exp[2] = PD_CSR;
      cls_inst[3] = 32'h5800_0000; cls_exp[3] = PD_BRANCH;
      cls_inst[4] = 32'h4C00_0000; cls_exp[4] = PD_JUMP;
      cls_inst[5] = 32'h5400_0000; cls_exp[5] = PD_JUMP;
      for (int k = 0; k < 3; k++)
         cyc(2, 32'h1C00_0300 + 32'(8 * k), cls_inst[2*k], cls_inst[2*k+1], 2'b00, 1'b0);
      chk("cls_occ", bus.occupancy, 6);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("cls_%0d", k), bus.out_class, cls_exp[k]);
         cyc(0, 0, 0, 0, 2'b00, 1'b1);
      end

      // fill/drain passes with wrap, checking in_ready threshold
      push_pc = 32'h1C00_1000;
      exp_pc  = 32'h1C00_1000;
      for (int pass = 0; pass < 3; pass++) begin
         for (int k = 0; k < 3; k++) begin
            cyc(2, push_pc, ALU, ALU, 2'b00, 1'b0);
            push_pc += 8;
         end
         chk("fill_occ6", bus.occupancy, 6);
         chk("fill_rdy6", bus.in_ready,  1);
         cyc(1, push_pc, ALU, ALU, 2'b00, 1'b0);
         push_pc += 4;
         chk("fill_occ7", bus.occupancy, 7);
         chk("fill_rdy7", bus.in_ready,  0);
         chk("fill_pc_first", bus.out_pc, exp_pc);
         cyc(0, 0, 0, 0, 2'b00, 1'b1);
         exp_pc += 4;
         cyc(2, push_pc, ALU, ALU, 2'b00, 1'b0);
         push_pc += 8;
         chk("fill_occ8", bus.occupancy, 8);
         chk("fill_rdy8", bus.in_ready,  0);
         for (int k = 0; k < 8; k++) begin
            chk("drain_pc", bus.out_pc, exp_pc);
            cyc(0, 0, 0, 0, 2'b00, 1'b1);
            exp_pc += 4;
         end
         chk("drain_occ", bus.occupancy, 0);
      end

      // flush with simultaneous push and pop at occupancy 5
      cyc(2, 32'h1C00_2000, ALU, ALU, 2'b00, 1'b0);
      cyc(2, 32'h1C00_2008, ALU, ALU, 2'b00, 1'b0);
      cyc(1, 32'h1C00_2010, ALU, ALU, 2'b00, 1'b0);
      chk("fl_pre_occ", bus.occupancy, 5);
      bus.flush = 1'b1;
      cyc(2, 32'h1C00_2014, ALU, ALU, 2'b00, 1'b1);
      chk("fl_occ", bus.occupancy, 0);
      chk("fl_vld", bus.out_valid, 0);
      chk("fl_rdy", bus.in_ready,  1);
      cyc(1, 32'h1C00_2800, ALU, ALU, 2'b00, 1'b0);
      chk("fl_after_pc", bus.out_pc, 32'h1C00_2800);
      cyc(0, 0, 0, 0, 2'b00, 1'b1);

      // steady push 1 / pop 1 at occupancy 3
      push_pc = 32'h1C00_3000;
      exp_pc  = 32'h1C00_3000;
      cyc(2, push_pc, ALU, ALU, 2'b00, 1'b0);
      push_pc += 8;
      cyc(1, push_pc, ALU, ALU, 2'b00, 1'b0);
      push_pc += 4;
      chk("st_occ_start", bus.occupancy, 3);
      for (int k = 0; k < 20; k++) begin
         chk("st_pc", bus.out_pc, exp_pc);
         cyc(1, push_pc, ALU, ALU, 2'b00, 1'b1);
         push_pc += 4;
         exp_pc  += 4;
         chk("st_occ", bus.occupancy, 3);
      end

      // asynchronous reset between edges
      rst = 1'b1;
      #1;
      chk("arst_occ", bus.occupancy, 0);
      chk("arst_vld", bus.out_valid, 0);
      chk("arst_rdy", bus.in_ready,  1);
      rst = 1'b0;
      tick();

      // latency from empty with decode ready
      drive(1, 32'h1C00_4000, ALU, ALU, 2'b00, 1'b1);
      #1;
`ifdef INST_BUFFER_BYPASS_EN
      chk("byp_vld", bus.out_valid, 1);
      chk("byp_pc",  bus.out_pc,    32'h1C00_4000);
      tick(); idle(); #1;
      chk("byp_occ", bus.occupancy, 0);
      chk("byp_vld_after", bus.out_valid, 0);
`else
      chk("nobyp_vld", bus.out_valid, 0);
      tick(); idle(); #1;
      chk("nobyp_occ", bus.occupancy, 1);
      chk("nobyp_vld_next", bus.out_valid, 1);
      chk("nobyp_pc", bus.out_pc, 32'h1C00_4000);
      cyc(0, 0, 0, 0, 2'b00, 1'b1);
      chk("nobyp_occ_end", bus.occupancy, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Parametrised instruction buffer between fetch and decode. Accepts up to FETCH_WIDTH sequential instructions per cycle, predecodes each into a coarse class, and hands one instruction per cycle to decode over a valid/ready handshake. A flush from branch-miss recovery discards all buffered entries. Replaces the direct fetch-to-decode connection so fetch can run ahead of decode stalls.

## Interface
- DEPTH, 8, entries; power of two, DEPTH >= FETCH_WIDTH
- FETCH_WIDTH, 2, max instructions pushed per cycle (1..4)
- INST_WIDTH, 32, instruction width
- ADDR_WIDTH, 32, PC width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard all entries (branch predict miss / exception)
- in_count  in  $clog2(FETCH_WIDTH+1)  lanes valid this cycle, contiguous from lane 0; 0 = no push
- in_inst  in  FETCH_WIDTH*INST_WIDTH  lane i at bits [i*INST_WIDTH +: INST_WIDTH]
- in_pc  in  ADDR_WIDTH  PC of lane 0; lane i PC = in_pc + 4*i
- in_pred_taken  in  FETCH_WIDTH  per-lane predicted-taken flag
- in_pred_addr  in  ADDR_WIDTH  predicted target, attached to the first lane with pred_taken set
- in_ready  out  1  buffer can accept FETCH_WIDTH lanes this cycle
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head
- out_inst / out_pc / out_pred_addr  out  INST_WIDTH / ADDR_WIDTH / ADDR_WIDTH  head fields
- out_pred_taken  out  1  head predicted-taken
- out_class  out  3  predecode class of head (pd_class_t)
- occupancy  out  $clog2(DEPTH+1)  current entry count

## Operation
- Circular storage, head/tail pointers of $clog2(DEPTH) bits wrapping mod DEPTH, occupancy counter.
- Push when in_ready && in_count != 0: lanes 0..in_count-1 written at tail..tail+in_count-1 (wrapping); tail += in_count; in_count > 0 while !in_ready is dropped (fetch's fault, assertion fires).
- in_ready = (DEPTH - occupancy) >= FETCH_WIDTH; registered state only, no path from out_ready.
- Lanes after the first pred_taken lane within a push are discarded (not written); in_count is truncated accordingly.
- Pop when out_valid && out_ready: head += 1.
- Push and pop in same cycle: occupancy += pushed - 1.
- Predecode at write, stored per entry: inst[31:30]==01 and inst[29:26] in {B,BL,JIRL} -> PD_JUMP; inst[31:30]==01 otherwise -> PD_BRANCH; inst[31:29]==001 and inst[28:24]==01001 -> PD_STORE; inst[31:29]==001 otherwise -> PD_LOAD; inst[31:24]==00000100 -> PD_CSR; else PD_ALU.
- flush: next cycle occupancy=0, head=tail=0, out_valid=0; flush dominates simultaneous push and pop (neither takes effect).
- Reset: occupancy 0, pointers 0, out_valid 0, in_ready 1, out_* data 0; entry storage need not be cleared.

## Timing
- Push-to-out_valid latency 1 cycle (buffer empty, no bypass).
- out_* driven from head entry; stable while out_valid && !out_ready.
- in_ready and out_valid are functions of registered state (plus bypass path below).
- Reset asserted mid-operation clears state immediately, asynchronously.

## Configuration
- INST_BUFFER_BYPASS_EN defined: when occupancy==0, no flush, and in_count>0, lane 0 appears combinationally on out_* the same cycle (out_valid=1); if out_ready, lane 0 is not written and only lanes 1.. are stored. Latency 0.
- Undefined: no bypass; out_* from storage only; latency 1.

## Structure
- Shared package: pd_class_t enum (PD_ALU=0, PD_BRANCH, PD_JUMP, PD_LOAD, PD_STORE, PD_CSR), entry struct {inst, pc, pred_taken, pred_addr, class}.
- Opcode constants (B, BL, JIRL) from the existing opcode header.
- One sub-module: inst_predecode (pure combinational, instruction -> pd_class_t), instantiated per lane.

## Test plan
- Reset, push in_count=2 {0x02800421 @0x1C000000, 0x50000400 @0x1C000004} -> next cycle out_valid=1, out_pc=0x1C000000, out_class=PD_ALU; after pop out_class=PD_JUMP, out_pc=0x1C000004.
- out_ready=0, push 2 per cycle from empty, DEPTH=8 -> in_ready falls when occupancy=7; occupancy never exceeds 8; wrap order preserved after 3 full fill/drain passes.
- Push 2 with in_pred_taken=2'b01, in_pred_addr=0x1C000100 -> only lane 0 stored, occupancy=1, out_pred_taken=1, out_pred_addr=0x1C000100.
- Occupancy 5, flush with simultaneous push and pop -> next cycle occupancy=0, out_valid=0, in_ready=1.
- Steady push 1/pop 1 at occupancy 3 for 20 cycles -> occupancy stays 3, PCs in order.
- With INST_BUFFER_BYPASS_EN, empty, push 1, out_ready=1 -> out_valid same cycle, occupancy remains 0; without macro -> out_valid next cycle.
